// File: rtl/serial_word_comparator.sv
// serial_word_comparator: MSB-first digit-serial magnitude compare of two N-bit words, K bits per clock.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing digit instead of always scanning D digits.
module serial_word_comparator #(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] wordA,
  input  logic [N-1:0] wordB,
  input  logic         signed_mode,
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         eq,
  output logic         lt
);
  localparam int D  = N / K;
  localparam int CW = $clog2(D) + 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] idx_q, idx_d;
  logic sgt_q, sgt_d, slt_q, slt_d;
  logic gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic [K-1:0] da, db;
  logic last;
  assign da   = a_q[N-1 -: K];
  assign db   = b_q[N-1 -: K];
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign last = (idx_q == CW'(D - 1)) || (da != db);
`else
  assign last = (idx_q == CW'(D - 1));
`endif
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    sgt_d   = sgt_q;
    slt_d   = slt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: if (start) begin
        // flipping the sign bit maps two's complement onto an unsigned order
        a_d     = wordA ^ (N'(signed_mode) << (N - 1));
        b_d     = wordB ^ (N'(signed_mode) << (N - 1));
        idx_d   = '0;
        sgt_d   = 1'b0;
        slt_d   = 1'b0;
        gt_d    = 1'b0;
        eq_d    = 1'b0;
        lt_d    = 1'b0;
        state_d = SCAN;
      end
      SCAN: begin
        a_d   = a_q << K;
        b_d   = b_q << K;
        idx_d = idx_q + CW'(1);
        if (!sgt_q && !slt_q) begin
          sgt_d = da > db;
          slt_d = da < db;
        end
        if (last) begin
          gt_d    = sgt_d;
          lt_d    = slt_d;
          eq_d    = !sgt_d && !slt_d;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      sgt_q   <= 1'b0;
      slt_q   <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      sgt_q   <= sgt_d;
      slt_q   <= slt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end
endmodule

// File: tb/tb_serial_word_comparator.sv
// tb_serial_word_comparator: directed scoreboard bench for serial_word_comparator (N=8, K=2).
module tb_serial_word_comparator;
  localparam int N = 8;
  localparam int K = 2;
  localparam int D = N / K;
  logic clk = 0, rst_n = 1, start = 0, signed_mode = 0;
  logic [N-1:0] wordA = '0, wordB = '0;
  logic busy, done, gt, eq, lt;
  int errors = 0, checks = 0;
  typedef struct {logic [2:0] r; int lat;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  serial_word_comparator #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wordA(wordA), .wordB(wordB),
    .signed_mode(signed_mode), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // result from native compares; latency counted in cycles after the accepting edge
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    exp_t e;
    logic g, l;
    g = s ? ($signed(a) > $signed(b)) : (a > b);
    l = s ? ($signed(a) < $signed(b)) : (a < b);
    e.r = {g, !g && !l, l};
    e.lat = D + 1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = D - 1; i >= 0; i--)
      if (a[N-1-i*K -: K] != b[N-1-i*K -: K]) e.lat = i + 2;
`endif
    return e;
  endfunction
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    @(negedge clk);
    wordA = a; wordB = b; signed_mode = s; start = 1;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    start = 0; wordA = ~a; wordB = ~b; signed_mode = ~s;
    chk("busy_scan", busy, 1);
    chk("flags_clear", {gt, eq, lt}, 0);
  endtask
  task automatic finish_cmp(input string tag);
    exp_t e;
    logic [2:0] r;
    int n;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, done, 1);
    e = sb.pop_front();
    r = {gt, eq, lt};
    chk({tag, "_lat"}, n, e.lat);
    chk({tag, "_res"}, r, e.r);
    @(negedge clk);
    chk({tag, "_pulse"}, {busy, done}, 0);
    chk({tag, "_hold"}, {gt, eq, lt}, r);
  endtask
  logic [N-1:0] va[10] = '{8'h5A, 8'h80, 8'h80, 8'h03, 8'h00, 8'hFF, 8'hFF, 8'h7F, 8'hFE, 8'h40};
  logic [N-1:0] vb[10] = '{8'h5A, 8'h7F, 8'h7F, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'hFF, 8'hC0};
  logic         vs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  initial begin
    int n;
    logic seen;
    exp_t e;
    #2 rst_n = 0;
    #1 chk("reset_out", {busy, done, gt, eq, lt}, 0);
    @(negedge clk);
    rst_n = 1;
    launch(8'h5A, 8'h5A, 1'b0);
    @(negedge clk);
    rst_n = 0;
    #1 chk("midscan_reset", {busy, done, gt, eq, lt}, 0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= done | busy;
    end
    chk("no_done_after_abort", seen, 0);
    for (int i = 0; i < 10; i++) begin
      launch(va[i], vb[i], vs[i]);
      finish_cmp($sformatf("vec%0d", i));
    end
    @(negedge clk);
    wordA = 8'h10; wordB = 8'h20; signed_mode = 0; start = 1;
    sb.push_back(model(8'h10, 8'h20, 1'b0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      wordA = N'($urandom); wordB = N'($urandom); signed_mode = 1'($urandom);
    end while (!done && n < 20);
    chk("hold_done", done, 1);
    e = sb.pop_front();
    chk("hold_lat", n, e.lat);
    chk("hold_res", {gt, eq, lt}, e.r);
    @(negedge clk);
    chk("hold_idle", busy, 0);
    chk("hold_keep", {gt, eq, lt}, e.r);
    wordA = 8'hFF; wordB = 8'h00; signed_mode = 0;
    sb.push_back(model(8'hFF, 8'h00, 1'b0));
    @(negedge clk);
    start = 0; wordA = 8'h00; wordB = 8'hFF;
    chk("rearm_busy", busy, 1);
    chk("rearm_clear", {gt, eq, lt}, 0);
    finish_cmp("rearm");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_word_comparator.md
Name: serial_word_comparator

Overview:
- Multi-cycle magnitude comparator for two N-bit words.
- Scans left to right, MSB first, K bits (one digit) per clock, and reports greater, equal or less.
- Parametrised sequential successor to the combinational comparator: configurable width and digit size, signed/unsigned mode, start/done handshake.
- Sits in the datapath wherever an area-cheap compare is acceptable in exchange for latency.

Parameters:
- N, 8, operand width in bits; must be a multiple of K.
- K, 2, bits compared per clock (digit width); 1 <= K <= N.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a compare; sampled only in IDLE.
- wordA  input  N  operand A; captured on accepted start.
- wordB  input  N  operand B; captured on accepted start.
- signed_mode  input  1  1 = two's complement compare, 0 = unsigned; captured on accepted start.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse when the result becomes valid.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; busy, done, gt, eq, lt = 0.
  - Internal operand registers, digit counter and sticky flags cleared.
  - Reset mid-scan aborts immediately; no done is produced.
- Number of digits: D = N/K. Digit index i=0 is bits [N-1:N-K].
- IDLE:
  - start=1 latches wordA, wordB and signed_mode, clears gt/eq/lt to 0, sets digit index to 0, then goes to SCAN.
  - start=0: stays in IDLE; gt/eq/lt hold the last result.
- SCAN, one digit per cycle:
  - Digit compare is unsigned on the K-bit slices.
  - In signed mode the operand MSB (bit N-1) of both words is inverted before slicing (offset-binary trick), so digit 0 compares correctly.
  - Sticky decision flag: the first unequal digit records gt or lt. Later digits are ignored.
  - After digit D-1 is processed, go to DONE.
- DONE (exactly one cycle):
  - done=1; gt/eq/lt are registered with exactly one high (eq=1 iff no digit differed).
  - Next state is IDLE.
- Latency without early exit:
  - Start accepted at edge t.
  - SCAN occupies cycles t+1 .. t+D.
  - done is high during cycle t+D+1.
- Handshake:
  - start is ignored while busy=1; it is not queued.
  - start in the same cycle done=1 is ignored; it must be reasserted in IDLE.
  - Operands may change freely after the accepting edge.
- Result hold: gt/eq/lt stay stable from the done cycle until the next accepted start.
- Boundaries:
  - K=N gives D=1, so a single SCAN cycle.
  - Digit counter width is clog2(D)+1 and must not wrap before D-1 is reached.
  - All-zero operands and all-ones operands both give eq=1.
  - Most negative versus most positive value must be handled correctly in signed mode.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined:
  - In SCAN, the first cycle whose digit differs transitions directly to DONE.
  - Latency is (index of first differing digit)+1 SCAN cycles.
  - Equal operands still take D SCAN cycles.
- Undefined:
  - Always D SCAN cycles, giving data-independent constant latency. Intended for timing-side-channel-sensitive use.
- Result values are identical in both builds; only done timing differs.

Test Plan (N=8, K=2, D=4, start accepted at edge t):
- Reset mid-scan: rst_n low during cycle t+2 -> busy, done, gt, eq, lt = 0 immediately; no done pulse; the next start completes normally.
- Equal operands: A=0x5A, B=0x5A, unsigned -> eq=1, gt=lt=0; done high in cycle t+5 in both builds.
- Unsigned MSB difference: A=0x80, B=0x7F, unsigned -> gt=1.
  - Early-exit build: done in cycle t+2.
  - Constant-latency build: done in cycle t+5.
- Signed mode: A=0x80 (-128), B=0x7F (+127), signed_mode=1 -> lt=1, gt=eq=0.
- LSB-digit difference: A=0x03, B=0x01, unsigned -> gt=1; done in cycle t+5 in both builds.
- Handshake hold: start held high through busy with changing operands -> only the first operands are compared; gt/eq/lt stay stable after done until the next accepted start, where they clear to 0.
